irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_pkg.sv | 38 +++
 rtl/irq_sync_edge.sv | 46 ++++
 rtl/irq_controller.sv | 167 ++++++++++++++++
 tb/tb_irq_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared definitions for the interrupt controller: FSM state
//               encoding, register offsets (addr[4:3]) and the lowest-index
//               priority encoder used to pick the CAUSE on acknowledge.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

  localparam int NSRC_MAX = 16;
  localparam int CAUSE_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CAUSE   = 2'd2;
  localparam logic [1:0] REG_EOI     = 2'd3;

  // Index of the lowest set bit; 0 when the vector is empty (callers only
  // use the result when at least one bit is set).
  function automatic logic [CAUSE_W-1:0] lowest_set(input logic [NSRC_MAX-1:0] vec);
    logic [CAUSE_W-1:0] idx;
    idx = '0;
    for (int i = NSRC_MAX - 1; i >= 0; i--) begin
      if (vec[i]) idx = CAUSE_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : One interrupt source: 2-flop synchronizer followed by a
//               rising-edge detector with its own history flop.
// Ports       : clk        - clock
//               reset      - asynchronous active-low reset
//               src        - asynchronous source input
//               edge_pulse - one-cycle pulse on a synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = src;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // History flop resets to 0, so a source already high at reset release
  // produces exactly one event.
  assign edge_pulse = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : NSRC-source interrupt controller with PENDING (W1C), MASK,
//               CAUSE and EOI registers and an IDLE/REQ/SERVICE handshake
//               FSM driving a registered ExtIRQ.
// Ports       : clk, reset (async active-low)
//               irq_src[NSRC]  - asynchronous sources, rising edge = event
//               ExtIRQ         - registered request to the processor
//               ExtIAck        - processor acknowledge (level)
//               cs, addr, writeData, writeEnable, readEnable, readData
//                              - bus slave; addr[4:3] selects the register
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int NSRC = 8,
  parameter int N    = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  output logic            ExtIRQ,
  input  logic            ExtIAck,
  input  logic            cs,
  input  logic [N-1:0]    addr,
  input  logic [N-1:0]    writeData,
  input  logic            writeEnable,
  input  logic            readEnable,
  output logic [N-1:0]    readData
);

  import irq_pkg::*;

  logic [NSRC-1:0]     edge_vec;
  logic [NSRC-1:0]     pending_q, pending_d;
  logic [NSRC-1:0]     mask_q,    mask_d;
  logic [CAUSE_W-1:0]  cause_q,   cause_d;
  irq_state_e          state_q,   state_d;
  logic                ext_irq_q, ext_irq_d;

  logic [NSRC-1:0]     active;
  logic [CAUSE_W-1:0]  first_idx;
  logic [1:0]          reg_sel;
  logic                bus_wr;
  logic                eoi_wr;
  logic                ack_take;
  logic                unused_bits;

  // --------------------------------------------------------------------------
  // Per-source synchronizer and edge detector
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_sync_edge u_sync_edge (
      .clk        (clk),
      .reset      (reset),
      .src        (irq_src[i]),
      .edge_pulse (edge_vec[i])
    );
  end

  assign reg_sel   = addr[4:3];
  assign bus_wr    = cs & writeEnable;
  assign eoi_wr    = bus_wr && (reg_sel == REG_EOI);
  assign active    = pending_q & mask_q;
  assign first_idx = lowest_set(NSRC_MAX'(active));
  // Ack only takes effect while a masked-in request is still outstanding;
  // an emptied request falls back to IDLE instead.
  assign ack_take  = (state_q == ST_REQ) && ExtIAck && (active != '0);

  assign unused_bits = ^{addr[N-1:5], addr[2:0], writeData[N-1:NSRC]};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ext_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_irq_q <= ext_irq_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (active != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (active == '0)  state_d = ST_IDLE;
        else if (ExtIAck)  state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eoi_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. ExtIRQ is decoded from the next state and registered
  // alongside it, so it is a glitch-free Moore output that is 1 only in REQ.
  // --------------------------------------------------------------------------
  always_comb begin
    ext_irq_d = (state_d == ST_REQ);
  end

  assign ExtIRQ = ext_irq_q;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    cause_d   = cause_q;

    if (bus_wr && (reg_sel == REG_PENDING)) begin
      pending_d = pending_d & ~writeData[NSRC-1:0];
    end
    if (bus_wr && (reg_sel == REG_MASK)) begin
      mask_d = writeData[NSRC-1:0];
    end
    if (ack_take) begin
      cause_d = first_idx;
      for (int i = 0; i < NSRC; i++) begin
        if (first_idx == CAUSE_W'(i)) pending_d[i] = 1'b0;
      end
    end
    // New events are applied last so a simultaneous clear never loses them.
    pending_d = pending_d | edge_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
    end
  end

  // --------------------------------------------------------------------------
  // Combinational read mux
  // --------------------------------------------------------------------------
  always_comb begin
    readData = '0;
    if (cs && readEnable) begin
      unique case (reg_sel)
        REG_PENDING: readData[NSRC-1:0]    = pending_q;
        REG_MASK:    readData[NSRC-1:0]    = mask_q;
        REG_CAUSE:   readData[CAUSE_W-1:0] = cause_q;
        default:     readData              = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Self-checking bench for irq_controller: a table of register
//               accesses after reset, then directed handshake sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int NSRC = 8;
  localparam int N    = 64;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_MASK  = 2'd1;
  localparam logic [1:0] A_CAUSE = 2'd2;
  localparam logic [1:0] A_EOI   = 2'd3;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] irq_src;
  logic            ExtIRQ;
  logic            ExtIAck;
  logic            cs;
  logic [N-1:0]    addr;
  logic [N-1:0]    writeData;
  logic            writeEnable;
  logic            readEnable;
  logic [N-1:0]    readData;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NSRC(NSRC), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .ExtIRQ      (ExtIRQ),
    .ExtIAck     (ExtIAck),
    .cs          (cs),
    .addr        (addr),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .readData    (readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic        cs;
    logic        re;
    logic [63:0] addr;
    logic [63:0] data;   // write data, or expected read data
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write_a(input logic [63:0] a, input logic [63:0] d);
    cs = 1'b1; writeEnable = 1'b1; addr = a; writeData = d;
    tick();
    cs = 1'b0; writeEnable = 1'b0; addr = '0; writeData = '0;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [63:0] d);
    bus_write_a({59'd0, r, 3'd0}, d);
  endtask

  task automatic rd(input logic [1:0] r, output logic [63:0] v);
    cs = 1'b1; readEnable = 1'b1; addr = {59'd0, r, 3'd0};
    #1;
    v = readData;
    cs = 1'b0; readEnable = 1'b0; addr = '0;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] r, input logic [63:0] exp);
    logic [63:0] v;
    rd(r, v);
    chk(name, v, exp);
  endtask

  task automatic ack_cycle();
    ExtIAck = 1'b1;
    tick();
    ExtIAck = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_src = '0; ExtIAck = 1'b0; cs = 1'b0; addr = '0;
    writeData = '0; writeEnable = 1'b0; readEnable = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 64'h0,                 64'h0,                 "rst_pending"};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 64'h8,                 64'h0,                 "rst_mask"};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 64'h10,                64'h0,                 "rst_cause"};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 64'h18,                64'h0,                 "eoi_reads_zero"};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 64'h8,                 64'hA5,                "wr_mask_a5"};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 64'h8,                 64'hA5,                "mask_rw"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 64'h8,                 64'h0,                 "no_read_enable"};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 64'h8,                 64'h0,                 "no_cs"};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF08, 64'hFFFF_FFFF_FFFF_FF3C, "wr_mask_wide"};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 64'h1008,              64'h3C,                "mask_upper_ignored"};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 64'h10,                64'hFF,                "wr_cause"};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 64'h10,                64'h0,                 "cause_read_only"};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 64'h8,                 64'h0,                 "wr_mask_zero"};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 64'h8,                 64'h0,                 "mask_cleared"};

    // Reset phase
    repeat (3) tick();
    chk("irq_in_reset", {63'd0, ExtIRQ}, 64'd0);
    reset = 1'b1;
    tick();

    // Table-driven register access
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write_a(vecs[i].addr, vecs[i].data);
      end else begin
        logic [63:0] v;
        cs = vecs[i].cs; readEnable = vecs[i].re; addr = vecs[i].addr;
        #1;
        v = readData;
        cs = 1'b0; readEnable = 1'b0; addr = '0;
        chk(vecs[i].name, v, vecs[i].data);
      end
    end

    // Basic handshake on source 0
    bus_write(A_MASK, 64'h01);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    tick();
    chk_reg("a_pend_early", A_PEND, 64'h00);
    tick();
    chk_reg("a_pend_set", A_PEND, 64'h01);
    chk("a_irq_not_yet", {63'd0, ExtIRQ}, 64'd0);
    tick();
    chk("a_irq_raised", {63'd0, ExtIRQ}, 64'd1);
    ack_cycle();
    chk("a_irq_dropped", {63'd0, ExtIRQ}, 64'd0);
    chk_reg("a_cause", A_CAUSE, 64'h0);
    chk_reg("a_pend_cleared", A_PEND, 64'h00);
    bus_write(A_EOI, 64'h0);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    repeat (3) tick();
    chk("a_idle_after_eoi", {63'd0, ExtIRQ}, 64'd1);
    ack_cycle();
    bus_write(A_EOI, 64'h0);

    // Two simultaneous sources, lowest index first
    bus_write(A_MASK, 64'hFF);
    irq_src = 8'h24;
    repeat (3) tick();
    chk_reg("b_pend_both", A_PEND, 64'h24);
    tick();
    chk("b_irq1", {63'd0, ExtIRQ}, 64'd1);
    ack_cycle();
    chk("b_irq1_drop", {63'd0, ExtIRQ}, 64'd0);
    chk_reg("b_cause2", A_CAUSE, 64'h2);
    chk_reg("b_pend_left", A_PEND, 64'h20);
    ack_cycle();
    chk_reg("b_ack_ignored_pend", A_PEND, 64'h20);
    chk_reg("b_ack_ignored_cause", A_CAUSE, 64'h2);
    chk("b_service_holds", {63'd0, ExtIRQ}, 64'd0);
    bus_write(A_EOI, 64'h0);
    tick();
    chk("b_irq2", {63'd0, ExtIRQ}, 64'd1);
    ack_cycle();
    chk_reg("b_cause5", A_CAUSE, 64'h5);
    chk_reg("b_pend_empty", A_PEND, 64'h00);
    bus_write(A_EOI, 64'h0);
    irq_src = '0;
    repeat (3) tick();

    // Masked source still pends; unmasking raises the request
    bus_write(A_MASK, 64'h00);
    irq_src[3] = 1'b1; tick(); irq_src[3] = 1'b0;
    repeat (2) tick();
    chk_reg("c_masked_pends", A_PEND, 64'h08);
    repeat (2) tick();
    chk("c_masked_no_irq", {63'd0, ExtIRQ}, 64'd0);
    bus_write(A_MASK, 64'h08);
    chk("c_irq_not_on_write", {63'd0, ExtIRQ}, 64'd0);
    tick();
    chk("c_irq_after_unmask", {63'd0, ExtIRQ}, 64'd1);

    // W1C withdraws the request before ack
    bus_write(A_PEND, 64'h08);
    chk_reg("d_w1c_cleared", A_PEND, 64'h00);
    tick();
    chk("d_back_to_idle", {63'd0, ExtIRQ}, 64'd0);
    chk_reg("d_cause_kept", A_CAUSE, 64'h5);
    bus_write(A_MASK, 64'h00);
    irq_src[3] = 1'b1; tick(); irq_src[3] = 1'b0;
    repeat (2) tick();
    irq_src[3] = 1'b1; tick(); irq_src[3] = 1'b0;
    tick();
    bus_write(A_PEND, 64'h08);           // coincides with the second edge
    chk_reg("d_set_wins", A_PEND, 64'h08);
    bus_write(A_PEND, 64'h08);
    chk_reg("d_w1c_plain", A_PEND, 64'h00);

    // Reset during SERVICE with a source held high across release
    bus_write(A_MASK, 64'hFF);
    irq_src[1] = 1'b1;
    repeat (4) tick();
    chk("e_irq", {63'd0, ExtIRQ}, 64'd1);
    ack_cycle();
    chk_reg("e_cause1", A_CAUSE, 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("e_rst_irq", {63'd0, ExtIRQ}, 64'd0);
    chk_reg("e_rst_pend", A_PEND, 64'h0);
    chk_reg("e_rst_mask", A_MASK, 64'h0);
    chk_reg("e_rst_cause", A_CAUSE, 64'h0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk_reg("e_pend_not_yet", A_PEND, 64'h00);
    tick();
    chk_reg("e_one_event", A_PEND, 64'h02);
    chk("e_no_irq_masked", {63'd0, ExtIRQ}, 64'd0);
    bus_write(A_PEND, 64'h02);
    repeat (4) tick();
    chk_reg("e_no_second_event", A_PEND, 64'h00);
    chk_reg("e_cause_zero", A_CAUSE, 64'h0);
    irq_src = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
